pe_array_output_drain: RTL and testbench
========================================

Name: pe_array_output_drain

Overview:
- Read-side counterpart of the PE array load sequencing: sequences output_num_reg_en/r0w1 into PE_array per tile row, samples b_output_stream, and serializes the per-column results onto a valid/ready stream toward the output buffer.
- Sits between PE_array and the output SRAM/buffer.
- Replaces ad-hoc bench-driven output control with a reusable FSM.

Parameters:
- ROW_NUM, 4, PE array rows
- COLUMN_NUM, 4, PE array columns
- BINARY_OUTPUT_BITWIDTH, 8, width of one column result
- UNARY_WEIGHT_BITWIDTH, 16, compute cycles per tile row (2**BINARY_WEIGHT_BITWIDTH)
- ROW_CNT_BITWIDTH, 8, width of tile_count / row index
- COL_IDX_BITWIDTH, $clog2(COLUMN_NUM), column index width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a tile when idle
- tile_count  input  ROW_CNT_BITWIDTH  number of input-matrix rows to process (INPUT_MATRIX_HEIGHT)
- busy  output  1  high from the cycle after an accepted start until the done cycle
- done  output  1  one-cycle pulse when the tile completes
- output_num_reg_en  output  [ROW_NUM-1:0][COLUMN_NUM-1:0]  to PE_array
- output_num_reg_r0w1  output  [ROW_NUM-1:0][COLUMN_NUM-1:0]  to PE_array; 1=accumulate/write, 0=read
- b_output_stream  input  [COLUMN_NUM-1:0][BINARY_OUTPUT_BITWIDTH-1:0]  from PE_array
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accept
- out_data  output  BINARY_OUTPUT_BITWIDTH  result value (two's complement, passed through unmodified)
- out_col  output  COL_IDX_BITWIDTH  column index of the beat
- out_row  output  ROW_CNT_BITWIDTH  row index of the beat
- out_last  output  1  final beat of the tile

Behaviour:
- Reset (async, active-high): state=IDLE; every output 0; counters 0; capture register 0. Reset mid-operation aborts immediately. No partial beat is completed.
- States: IDLE, COMPUTE, READ, CAPTURE, DRAIN, DONE.
- IDLE: on start, latch tile_count and clear row.
  - tile_count==0 -> DONE.
  - Otherwise -> COMPUTE.
  - start outside IDLE is ignored.
- COMPUTE: lasts exactly UNARY_WEIGHT_BITWIDTH cycles (counter 0..UNARY_WEIGHT_BITWIDTH-1).
  - output_num_reg_en and r0w1 are all-ones.
  - Then -> READ.
- READ: one cycle, en=all-ones, r0w1=all-zeros -> CAPTURE.
- CAPTURE: one cycle (PE_array read latency 1).
  - en=0.
  - Register b_output_stream into the capture register.
  - Then -> DRAIN with col=0.
- DRAIN: out_valid=1, out_data=capture[col], out_col=col, out_row=row.
  - out_last=1 iff col==COLUMN_NUM-1 and row==tile_count_q-1.
  - Beat transfers when out_valid&&out_ready.
  - While out_valid&&!out_ready, all out_* are held stable.
  - out_valid never drops without a transfer.
  - On transfer of col==COLUMN_NUM-1: if row<tile_count_q-1, row++ and go to COMPUTE (same cycle the next COMPUTE count starts); otherwise go to DONE.
  - Other transfers: col++.
- DONE: done=1 for one cycle, busy=0, -> IDLE. start in DONE is ignored.
- busy=1 in COMPUTE, READ, CAPTURE, DRAIN.
- Per-row latency with out_ready held high: UNARY_WEIGHT_BITWIDTH+2+COLUMN_NUM cycles (22 at defaults).
- In all non-COMPUTE/READ states, output_num_reg_en=0 and r0w1=0.
- b_output_stream is sampled only in CAPTURE; changes at other times are ignored.
- Row counter does not wrap: maximum tile_count = 2**ROW_CNT_BITWIDTH-1.

Decomposition:
- Shared package pe_array_pkg holds:
  - the ROW_NUM/COLUMN_NUM/BINARY_OUTPUT_BITWIDTH/UNARY_WEIGHT_BITWIDTH constants (shared with PE_array);
  - the typedef enum drain_state_t {IDLE, COMPUTE, READ, CAPTURE, DRAIN, DONE};
  - typedef col_result_t ([COLUMN_NUM-1:0][BINARY_OUTPUT_BITWIDTH-1:0]).
- One sub-module, pe_out_serializer:
  - holds the capture register, column counter and valid/ready hold logic;
  - has ports load, load_data, last_row, out_*, drained (pulse on final-column transfer).
- The top level keeps the FSM, compute counter, row counter and PE control generation.

Test Plan:
- Reset mid-DRAIN (assert at col=2) -> next cycle all outputs 0, state IDLE; a subsequent start with tile_count=1 runs cleanly.
- tile_count=1, out_ready=1, b_output_stream={8'h04,8'hFD,8'h7F,8'h00} sampled in CAPTURE:
  - en/r0w1 all-ones for 16 cycles, then en=1/r0w1=0 for 1 cycle;
  - beats data 00,7F,FD,04 with col 0..3, out_last on col 3;
  - done on the following cycle; 22 cycles from first COMPUTE to last beat.
- tile_count=3, out_ready=1:
  - 12 beats with out_row 0,0,0,0,1,…,2;
  - out_last only on row 2 col 3;
  - exactly one done pulse;
  - b_output_stream changed outside CAPTURE has no effect.
- Backpressure, out_ready low for 5 cycles at col 1 -> out_data/out_col/out_row held identical, no beat lost or duplicated; COMPUTE for the next row starts only after col 3 transfers.
- tile_count=0 start -> done pulse 2 cycles after start, no en asserted, no out_valid.
- start pulsed during COMPUTE and during DONE -> ignored; no restart, counters unchanged.

Source files
------------

// File: rtl/pe_array_pkg.sv
`default_nettype none
// ============================================================================
// Package : pe_array_pkg
// Brief   : Shared PE array geometry, drain FSM states and column result type.
// Rev     : 1.0 - initial release
// ============================================================================
package pe_array_pkg;

  localparam int ROW_NUM                = 4;
  localparam int COLUMN_NUM             = 4;
  localparam int BINARY_OUTPUT_BITWIDTH = 8;
  localparam int UNARY_WEIGHT_BITWIDTH  = 16;
  localparam int ROW_CNT_BITWIDTH       = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPUTE = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } drain_state_t;

  typedef logic [COLUMN_NUM-1:0][BINARY_OUTPUT_BITWIDTH-1:0] col_result_t;

endpackage
`default_nettype wire

// File: rtl/pe_array_output_drain_serializer.sv
`default_nettype none
// ============================================================================
// Module : pe_out_serializer
// Brief  : Captures one PE row result and streams it column by column (valid/ready).
// Rev    : 1.0 - initial release
// ============================================================================
module pe_out_serializer #(
  parameter int COLUMN_NUM             = 4,
  parameter int BINARY_OUTPUT_BITWIDTH = 8,
  parameter int ROW_CNT_BITWIDTH       = 8,
  parameter int COL_IDX_BITWIDTH       = $clog2(COLUMN_NUM)
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             load,
  input  logic [COLUMN_NUM-1:0][BINARY_OUTPUT_BITWIDTH-1:0] load_data,
  input  logic [ROW_CNT_BITWIDTH-1:0]                      row,
  input  logic                                             last_row,
  input  logic                                             out_ready,
  output logic                                             out_valid,
  output logic [BINARY_OUTPUT_BITWIDTH-1:0]                out_data,
  output logic [COL_IDX_BITWIDTH-1:0]                      out_col,
  output logic [ROW_CNT_BITWIDTH-1:0]                      out_row,
  output logic                                             out_last,
  output logic                                             drained
);
  import pe_array_pkg::*;

  localparam logic [COL_IDX_BITWIDTH-1:0] C_LAST_COL = COL_IDX_BITWIDTH'(COLUMN_NUM - 1);

  logic [COLUMN_NUM-1:0][BINARY_OUTPUT_BITWIDTH-1:0] r_capture;
  logic [COL_IDX_BITWIDTH-1:0]                       r_col;
  logic                                              r_valid;
  logic                                              w_xfer;
  logic                                              w_last_col;

  assign w_xfer     = r_valid && out_ready;
  assign w_last_col = (r_col == C_LAST_COL);

  // Column index and capture only move on a transfer, so a stalled beat stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_capture <= '0;
      r_col     <= '0;
      r_valid   <= 1'b0;
    end else if (load) begin
      r_capture <= load_data;
      r_col     <= '0;
      r_valid   <= 1'b1;
    end else if (w_xfer) begin
      if (w_last_col) begin
        r_col   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_col   <= r_col + COL_IDX_BITWIDTH'(1);
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_valid ? r_capture[r_col] : '0;
  assign out_col   = r_valid ? r_col : '0;
  assign out_row   = r_valid ? row : '0;
  assign out_last  = r_valid && w_last_col && last_row;
  assign drained   = w_xfer && w_last_col;

endmodule
`default_nettype wire

// File: rtl/pe_array_output_drain.sv
`default_nettype none
// ============================================================================
// Module : pe_array_output_drain
// Brief  : Per-row compute/read sequencing of PE_array and result drain to the output buffer.
// Rev    : 1.0 - initial release
// ============================================================================
module pe_array_output_drain #(
  parameter int ROW_NUM                = pe_array_pkg::ROW_NUM,
  parameter int COLUMN_NUM             = pe_array_pkg::COLUMN_NUM,
  parameter int BINARY_OUTPUT_BITWIDTH = pe_array_pkg::BINARY_OUTPUT_BITWIDTH,
  parameter int UNARY_WEIGHT_BITWIDTH  = pe_array_pkg::UNARY_WEIGHT_BITWIDTH,
  parameter int ROW_CNT_BITWIDTH       = pe_array_pkg::ROW_CNT_BITWIDTH,
  parameter int COL_IDX_BITWIDTH       = $clog2(COLUMN_NUM)
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [ROW_CNT_BITWIDTH-1:0]                      tile_count,
  output logic                                             busy,
  output logic                                             done,
  output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]               output_num_reg_en,
  output logic [ROW_NUM-1:0][COLUMN_NUM-1:0]               output_num_reg_r0w1,
  input  logic [COLUMN_NUM-1:0][BINARY_OUTPUT_BITWIDTH-1:0] b_output_stream,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [BINARY_OUTPUT_BITWIDTH-1:0]                out_data,
  output logic [COL_IDX_BITWIDTH-1:0]                      out_col,
  output logic [ROW_CNT_BITWIDTH-1:0]                      out_row,
  output logic                                             out_last
);
  import pe_array_pkg::*;

  localparam int                CNT_W      = $clog2(UNARY_WEIGHT_BITWIDTH + 1);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(UNARY_WEIGHT_BITWIDTH - 1);

  drain_state_t                r_state;
  drain_state_t                w_next_state;
  logic [ROW_CNT_BITWIDTH-1:0] r_tile_count;
  logic [ROW_CNT_BITWIDTH-1:0] r_row;
  logic [CNT_W-1:0]            r_cnt;
  logic                        w_last_row;
  logic                        w_compute_end;
  logic                        w_load;
  logic                        w_drained;

  assign w_last_row    = (r_row == r_tile_count - ROW_CNT_BITWIDTH'(1));
  assign w_compute_end = (r_state == COMPUTE) && (r_cnt == C_CNT_LAST);
  assign w_load        = (r_state == CAPTURE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tile_count <= '0;
      r_row        <= '0;
      r_cnt        <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_tile_count <= tile_count;
        r_row        <= '0;
      end else if ((r_state == DRAIN) && w_drained && !w_last_row) begin
        r_row        <= r_row + ROW_CNT_BITWIDTH'(1);
      end
      // Held at zero outside COMPUTE so each row's compute window starts from 0.
      r_cnt <= ((r_state == COMPUTE) && !w_compute_end) ? r_cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = (tile_count == '0) ? DONE : COMPUTE;
      COMPUTE: if (w_compute_end) w_next_state = READ;
      READ:    w_next_state = CAPTURE;
      CAPTURE: w_next_state = DRAIN;
      DRAIN:   if (w_drained) w_next_state = w_last_row ? DONE : COMPUTE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy                = 1'b0;
    done                = 1'b0;
    output_num_reg_en   = '0;
    output_num_reg_r0w1 = '0;
    case (r_state)
      COMPUTE: begin
        busy                = 1'b1;
        output_num_reg_en   = '1;
        output_num_reg_r0w1 = '1;
      end
      READ: begin
        busy              = 1'b1;
        output_num_reg_en = '1;
      end
      CAPTURE: busy = 1'b1;
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  pe_out_serializer #(
    .COLUMN_NUM             (COLUMN_NUM),
    .BINARY_OUTPUT_BITWIDTH (BINARY_OUTPUT_BITWIDTH),
    .ROW_CNT_BITWIDTH       (ROW_CNT_BITWIDTH),
    .COL_IDX_BITWIDTH       (COL_IDX_BITWIDTH)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .load_data (b_output_stream),
    .row       (r_row),
    .last_row  (w_last_row),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_row   (out_row),
    .out_last  (out_last),
    .drained   (w_drained)
  );

endmodule
`default_nettype wire

// File: tb/tb_pe_array_output_drain.sv
`default_nettype none
// ============================================================================
// Module : tb_pe_array_output_drain
// Brief  : Self-checking bench with a behavioural PE_array read model and beat scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pe_array_output_drain;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int BW   = 8;
  localparam int RW   = 8;
  localparam int CW   = 2;

  typedef struct {
    logic [BW-1:0] data;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last;
  } beat_t;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       start;
  logic [RW-1:0]              tile_count;
  logic                       busy;
  logic                       done;
  logic [ROWS-1:0][COLS-1:0]  output_num_reg_en;
  logic [ROWS-1:0][COLS-1:0]  output_num_reg_r0w1;
  logic [COLS-1:0][BW-1:0]    b_output_stream;
  logic                       out_valid;
  logic                       out_ready;
  logic [BW-1:0]              out_data;
  logic [CW-1:0]              out_col;
  logic [RW-1:0]              out_row;
  logic                       out_last;

  pe_array_output_drain dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .tile_count          (tile_count),
    .busy                (busy),
    .done                (done),
    .output_num_reg_en   (output_num_reg_en),
    .output_num_reg_r0w1 (output_num_reg_r0w1),
    .b_output_stream     (b_output_stream),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .out_col             (out_col),
    .out_row             (out_row),
    .out_last            (out_last)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  beat_t exp_q[$];
  beat_t act_q[$];
  int    done_cnt, done_cyc, compute_cycles, read_cycles, first_compute_cyc, last_beat_cyc;
  int    hold_viol, overlap;
  int    exp_tiles, model_row;
  bit    pe_pending;
  bit    use_fixed;
  logic [COLS-1:0][BW-1:0] pe_value;
  logic [COLS-1:0][BW-1:0] fixed_value;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // PE_array model: a read (en=1, r0w1=0) makes a fresh row result appear one cycle later;
  // every other cycle the array output is junk that must never be captured.
  initial begin
    b_output_stream = '0;
    forever begin
      @(negedge clk);
      if (pe_pending) begin
        b_output_stream = pe_value;
        for (int c = 0; c < COLS; c++) begin
          beat_t b;
          b.data = pe_value[c];
          b.col  = CW'(c);
          b.row  = RW'(model_row);
          b.last = (c == COLS - 1) && (model_row == exp_tiles - 1);
          exp_q.push_back(b);
        end
        model_row  = model_row + 1;
        pe_pending = 1'b0;
      end else begin
        for (int c = 0; c < COLS; c++) b_output_stream[c] = BW'($urandom);
      end
      if (output_num_reg_en == '1 && output_num_reg_r0w1 == '0) begin
        pe_pending = 1'b1;
        if (use_fixed) pe_value = fixed_value;
        else for (int c = 0; c < COLS; c++) pe_value[c] = BW'($urandom);
      end
    end
  end

  // Passive recorder of what the DUT actually did each cycle.
  initial begin
    bit    stalled = 1'b0;
    beat_t held;
    forever begin
      @(negedge clk);
      if (stalled && (!out_valid || out_data !== held.data || out_col !== held.col ||
                      out_row !== held.row || out_last !== held.last))
        hold_viol = hold_viol + 1;
      held.data = out_data; held.col = out_col; held.row = out_row; held.last = out_last;
      stalled = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        act_q.push_back(held);
        last_beat_cyc = cyc;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (output_num_reg_en == '1 && output_num_reg_r0w1 == '1) begin
        if (compute_cycles == 0) first_compute_cyc = cyc;
        compute_cycles = compute_cycles + 1;
      end
      if (output_num_reg_en == '1 && output_num_reg_r0w1 == '0) read_cycles = read_cycles + 1;
      if (out_valid && output_num_reg_en != '0) overlap = overlap + 1;
    end
  end

  task automatic clear_stats();
    exp_q.delete(); act_q.delete();
    done_cnt = 0; done_cyc = -1; compute_cycles = 0; read_cycles = 0;
    first_compute_cyc = -1; last_beat_cyc = -1; hold_viol = 0; overlap = 0;
    model_row = 0; pe_pending = 1'b0;
  endtask

  task automatic start_tile(input int n);
    @(posedge clk); #1;
    exp_tiles  = n;
    start      = 1'b1;
    tile_count = RW'(n);
    @(posedge clk); #1;
    start      = 1'b0;
    tile_count = RW'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit rand_ready, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      if (done_cnt > 0) ok = 1'b1;
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tile_count = '0; out_ready = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, output_num_reg_en, output_num_reg_r0w1, out_valid, out_data, out_col, out_row, out_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {busy, done, output_num_reg_en, output_num_reg_r0w1, out_valid, out_data, out_col, out_row, out_last});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, out_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy/done/valid=%b required 000", {busy, done, out_valid});
    end
  endtask

  task automatic test_single_row();
    bit ok;
    logic [BW-1:0] want [COLS] = '{8'h00, 8'h7F, 8'hFD, 8'h04};
    clear_stats();
    use_fixed   = 1'b1;
    fixed_value = {8'h04, 8'hFD, 8'h7F, 8'h00};
    start_tile(1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b required 1", busy); end
    wait_done(100, 1'b0, ok);
    use_fixed = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: done seen 0 required 1"); end
    n_checks++;
    if (act_q.size() != COLS) begin n_fail++; $display("FAIL single_beats: got %0d required %0d", act_q.size(), COLS); end
    for (int i = 0; i < act_q.size() && i < COLS; i++) begin
      n_checks++;
      if (act_q[i].data !== want[i] || act_q[i].col !== CW'(i) || act_q[i].row !== '0 || act_q[i].last !== (i == COLS - 1)) begin
        n_fail++;
        $display("FAIL single_beat%0d: got d=%h c=%0d r=%0d l=%b required d=%h c=%0d r=0 l=%b",
                 i, act_q[i].data, act_q[i].col, act_q[i].row, act_q[i].last, want[i], i, i == COLS - 1);
      end
    end
    n_checks++;
    if (compute_cycles != 16 || read_cycles != 1) begin
      n_fail++; $display("FAIL single_pe_ctrl: compute=%0d read=%0d required 16 1", compute_cycles, read_cycles);
    end
    n_checks++;
    if (last_beat_cyc - first_compute_cyc + 1 != 22) begin
      n_fail++; $display("FAIL single_latency: got %0d required 22", last_beat_cyc - first_compute_cyc + 1);
    end
    n_checks++;
    if (done_cyc != last_beat_cyc + 1 || done_cnt != 1) begin
      n_fail++; $display("FAIL single_done: cyc=%0d cnt=%0d required cyc=%0d cnt=1", done_cyc, done_cnt, last_beat_cyc + 1);
    end
  endtask

  task automatic test_multi_row();
    bit ok;
    int lasts = 0;
    clear_stats();
    start_tile(3);
    wait_done(300, 1'b0, ok);
    n_checks++;
    if (!ok || act_q.size() != 3 * COLS) begin
      n_fail++; $display("FAIL multi_beats: done=%b beats=%0d required 1 %0d", ok, act_q.size(), 3 * COLS);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      if (act_q[i].last) lasts++;
      n_checks++;
      if (act_q[i].data !== exp_q[i].data || act_q[i].col !== exp_q[i].col ||
          act_q[i].row !== exp_q[i].row || act_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL multi_beat%0d: got d=%h c=%0d r=%0d l=%b required d=%h c=%0d r=%0d l=%b", i,
                 act_q[i].data, act_q[i].col, act_q[i].row, act_q[i].last,
                 exp_q[i].data, exp_q[i].col, exp_q[i].row, exp_q[i].last);
      end
    end
    n_checks++;
    if (lasts != 1 || done_cnt != 1 || compute_cycles != 48 || read_cycles != 3 || overlap != 0) begin
      n_fail++;
      $display("FAIL multi_summary: last=%0d done=%0d compute=%0d read=%0d overlap=%0d required 1 1 48 3 0",
               lasts, done_cnt, compute_cycles, read_cycles, overlap);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit found = 1'b0;
    beat_t h;
    clear_stats();
    start_tile(2);
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (out_valid && out_col == CW'(1)) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL bp_reach_col1: seen 0 required 1"); end
    h.data = out_data; h.col = out_col; h.row = out_row; h.last = out_last;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (!out_valid || out_data !== h.data || out_col !== h.col || out_row !== h.row || output_num_reg_en !== '0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%h c=%0d r=%0d en=%h required v=1 d=%h c=%0d r=%0d en=0",
                 i, out_valid, out_data, out_col, out_row, output_num_reg_en, h.data, h.col, h.row);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(200, 1'b0, ok);
    n_checks++;
    if (!ok || act_q.size() != 2 * COLS || hold_viol != 0 || overlap != 0 || compute_cycles != 32) begin
      n_fail++;
      $display("FAIL bp_summary: done=%b beats=%0d hold=%0d overlap=%0d compute=%0d required 1 %0d 0 0 32",
               ok, act_q.size(), hold_viol, overlap, compute_cycles, 2 * COLS);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i].data !== exp_q[i].data || act_q[i].col !== exp_q[i].col ||
          act_q[i].row !== exp_q[i].row || act_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got d=%h c=%0d r=%0d required d=%h c=%0d r=%0d", i,
                 act_q[i].data, act_q[i].col, act_q[i].row, exp_q[i].data, exp_q[i].col, exp_q[i].row);
      end
    end
  endtask

  task automatic test_random_ready();
    for (int t = 0; t < 3; t++) begin
      bit ok;
      int n = $urandom_range(1, 4);
      clear_stats();
      start_tile(n);
      wait_done(n * 150, 1'b1, ok);
      n_checks++;
      if (!ok || act_q.size() != n * COLS || exp_q.size() != n * COLS || hold_viol != 0 || overlap != 0 || done_cnt != 1) begin
        n_fail++;
        $display("FAIL rand%0d_summary: done=%b beats=%0d model=%0d hold=%0d overlap=%0d dones=%0d required 1 %0d %0d 0 0 1",
                 t, ok, act_q.size(), exp_q.size(), hold_viol, overlap, done_cnt, n * COLS, n * COLS);
      end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (act_q[i].data !== exp_q[i].data || act_q[i].col !== exp_q[i].col ||
            act_q[i].row !== exp_q[i].row || act_q[i].last !== exp_q[i].last) begin
          n_fail++;
          $display("FAIL rand%0d_beat%0d: got d=%h c=%0d r=%0d l=%b required d=%h c=%0d r=%0d l=%b", t, i,
                   act_q[i].data, act_q[i].col, act_q[i].row, act_q[i].last,
                   exp_q[i].data, exp_q[i].col, exp_q[i].row, exp_q[i].last);
        end
      end
    end
  endtask

  task automatic test_zero_tile();
    bit ok;
    int s;
    clear_stats();
    @(posedge clk); #1;
    exp_tiles = 0; start = 1'b1; tile_count = '0; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(10, 1'b0, ok);
    // The start cycle is the first of the two; done occupies the second.
    n_checks++;
    if (!ok || done_cyc != s + 1 || done_cnt != 1) begin
      n_fail++; $display("FAIL zero_done: cyc=%0d cnt=%0d required cyc=%0d cnt=1", done_cyc, done_cnt, s + 1);
    end
    n_checks++;
    if (compute_cycles + read_cycles != 0 || act_q.size() != 0) begin
      n_fail++; $display("FAIL zero_activity: en_cycles=%0d beats=%0d required 0 0", compute_cycles + read_cycles, act_q.size());
    end
  endtask

  task automatic test_start_ignored();
    bit seen = 1'b0;
    clear_stats();
    start_tile(2);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; tile_count = RW'(7);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        start = 1'b1; tile_count = RW'(5);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (!seen || busy !== 1'b0 || done_cnt != 1 || compute_cycles != 32 || act_q.size() != 2 * COLS) begin
      n_fail++;
      $display("FAIL ignore_start: done=%b busy=%b dones=%0d compute=%0d beats=%0d required 1 0 1 32 %0d",
               seen, busy, done_cnt, compute_cycles, act_q.size(), 2 * COLS);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i].data !== exp_q[i].data || act_q[i].row !== exp_q[i].row || act_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL ignore_beat%0d: got d=%h r=%0d l=%b required d=%h r=%0d l=%b", i,
                 act_q[i].data, act_q[i].row, act_q[i].last, exp_q[i].data, exp_q[i].row, exp_q[i].last);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    bit found = 1'b0;
    clear_stats();
    start_tile(1);
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (out_valid && out_col == CW'(2)) found = 1'b1;
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (!found || {busy, done, output_num_reg_en, output_num_reg_r0w1, out_valid, out_data, out_col, out_row, out_last} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: reached=%b outputs=%h required 1 0", found,
               {busy, done, output_num_reg_en, output_num_reg_r0w1, out_valid, out_data, out_col, out_row, out_last});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_stats();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, out_valid, output_num_reg_en} !== '0) begin
      n_fail++; $display("FAIL mid_reset_idle: got %h required 0", {busy, done, out_valid, output_num_reg_en});
    end
    start_tile(1);
    wait_done(100, 1'b0, ok);
    n_checks++;
    if (!ok || act_q.size() != COLS || done_cnt != 1) begin
      n_fail++; $display("FAIL mid_reset_rerun: done=%b beats=%0d dones=%0d required 1 %0d 1", ok, act_q.size(), done_cnt, COLS);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (act_q[i].data !== exp_q[i].data || act_q[i].col !== exp_q[i].col || act_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL mid_reset_beat%0d: got d=%h c=%0d l=%b required d=%h c=%0d l=%b", i,
                 act_q[i].data, act_q[i].col, act_q[i].last, exp_q[i].data, exp_q[i].col, exp_q[i].last);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    use_fixed = 1'b0;
    exp_tiles = 0;
    test_reset();
    test_single_row();
    test_multi_row();
    test_backpressure();
    test_random_ready();
    test_zero_tile();
    test_start_ignored();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
